// File: rtl/add_share_arb.sv
// Round-robin scheduler sharing one 16-bit parallel-prefix adder among NREQ requesters.
// Optional signed-overflow flag built when ADD_ARB_OVF_EN is defined.
module add_share_arb #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_ovf
);

  localparam int unsigned DW = 16;

  // Kogge-Stone prefix adder; carry-in folded into the bit-0 generate term.
  function automatic logic [DW:0] ppa_add(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic cin);
    logic [DW-1:0] g;
    logic [DW-1:0] p;
    logic [DW-1:0] h;
    h    = a ^ b;
    g    = a & b;
    g[0] = g[0] | (h[0] & cin);
    p    = h;
    for (int l = 0; l < 4; l++) begin
      g = g | (p & (g << (1 << l)));
      p = p & ((p << (1 << l)) | ~({DW{1'b1}} << (1 << l)));
    end
    return {g[DW-1], h ^ {g[DW-2:0], cin}};
  endfunction

  logic              op_vld;
  logic [DW-1:0]     op_a;
  logic [DW-1:0]     op_b;
  logic              op_cin;
  logic [IDW-1:0]    op_id;
  logic [IDW-1:0]    ptr;

  logic              rs_load;
  logic              op_acc;
  logic              op_take;
  logic              gnt_vld;
  logic [IDW-1:0]    gnt_idx;
  logic [IDW-1:0]    scan_idx;
  logic [DW:0]       add_res;

  assign rs_load = op_vld && (!rsp_valid || rsp_ready);
  assign op_acc  = !op_vld || rs_load;
  assign add_res = ppa_add(op_a, op_b, op_cin);

  // Rotating search starting just after the last granted requester.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      scan_idx = IDW'((32'(ptr) + i) % NREQ);
      if (!gnt_vld && req_valid[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  assign req_ready = (rst_n && op_acc && gnt_vld) ? (NREQ'(1) << gnt_idx) : '0;
  assign op_take   = |req_ready;

  // Operand stage and arbitration pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_vld <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
      op_id  <= '0;
      ptr    <= IDW'(NREQ - 1);
    end else begin
      if (op_take) begin
        op_vld <= 1'b1;
        op_a   <= req_a[DW*gnt_idx +: DW];
        op_b   <= req_b[DW*gnt_idx +: DW];
        op_cin <= req_cin[gnt_idx];
        op_id  <= gnt_idx;
        ptr    <= gnt_idx;
      end else if (rs_load) begin
        op_vld <= 1'b0;
      end
    end
  end

  // Result stage; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      if (rs_load) begin
        rsp_valid <= 1'b1;
        rsp_sum   <= add_res[DW-1:0];
        rsp_cout  <= add_res[DW];
        rsp_id    <= op_id;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ADD_ARB_OVF_EN
  // Signed overflow: like-signed operands producing an opposite-signed sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_ovf <= 1'b0;
    end else if (rs_load) begin
      rsp_ovf <= (op_a[DW-1] == op_b[DW-1]) && (add_res[DW-1] != op_a[DW-1]);
    end
  end
`else
  assign rsp_ovf = 1'b0;
`endif

endmodule
